axi_burst_arbiter: RTL and testbench

AXI_BURST_ARBITER -- requirements
Module: axi_burst_arbiter

---
 rtl/axi_burst_arbiter_if.sv | 32 +++
 rtl/axi_burst_arbiter.sv | 133 +++++++++++++
 tb/tb_axi_burst_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/axi_burst_arbiter_if.sv
// Channel-side and AXI-master-side signals of the burst arbiter.
// master = arbiter (drives grants and burst requests), slave = channels plus AXI master.
interface axi_burst_arbiter_if #(
    parameter int CH_NUM = 4,
    parameter int ADDR_W = 30,
    parameter int LEN_W  = 8
);
    logic [CH_NUM-1:0]        ch_req;
    logic [CH_NUM*ADDR_W-1:0] ch_beg_addr;
    logic [CH_NUM*ADDR_W-1:0] ch_end_addr;
    logic [CH_NUM*LEN_W-1:0]  ch_burst_len;
    logic [CH_NUM-1:0]        ch_addr_load;
    logic [CH_NUM-1:0]        ch_grant;
    logic [CH_NUM-1:0]        ch_done;
    logic                     axi_start;
    logic [ADDR_W-1:0]        axi_addr;
    logic [LEN_W-1:0]         axi_len;
    logic                     axi_ready;
    logic                     axi_done;

    modport master (
        input  ch_req, ch_beg_addr, ch_end_addr, ch_burst_len, ch_addr_load,
        input  axi_ready, axi_done,
        output ch_grant, ch_done, axi_start, axi_addr, axi_len
    );

    modport slave (
        output ch_req, ch_beg_addr, ch_end_addr, ch_burst_len, ch_addr_load,
        output axi_ready, axi_done,
        input  ch_grant, ch_done, axi_start, axi_addr, axi_len
    );
endinterface

// File: rtl/axi_burst_arbiter.sv
// Round-robin arbiter feeding one AXI burst master from CH_NUM circular address regions.
// axi_start 2 cycles after a request in IDLE; waits on axi_ready before arbitrating, holds grant until axi_done.
module axi_burst_arbiter #(
    parameter int CH_NUM = 4,
    parameter int ADDR_W = 30,
    parameter int LEN_W  = 8,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    axi_burst_arbiter_if.master bus
);
    localparam int BYTES  = DATA_W / 8;
    localparam int IDX_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int SPAN_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, ARB, START, WAIT} state_t;

    state_t              state_q;
    logic [CH_NUM-1:0]   grant_q;
    logic [CH_NUM-1:0]   done_q;
    logic [CH_NUM-1:0]   load_pend_q;
    logic                axi_start_q;
    logic [ADDR_W-1:0]   axi_addr_q;
    logic [LEN_W-1:0]    axi_len_q;
    logic [IDX_W-1:0]    rr_q;
    logic [IDX_W-1:0]    gnt_idx_q;
    logic [ADDR_W-1:0]   ptr_q [CH_NUM];

    logic                sel_vld_d;
    logic [IDX_W-1:0]    sel_idx_d;
    logic [IDX_W-1:0]    scan_idx;

    // Scan from the far end back toward rr_q so the closest requester wins.
    always_comb begin
        sel_vld_d = 1'b0;
        sel_idx_d = '0;
        scan_idx  = '0;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            scan_idx = IDX_W'((int'(rr_q) + k) % CH_NUM);
            if (bus.ch_req[scan_idx]) begin
                sel_vld_d = 1'b1;
                sel_idx_d = scan_idx;
            end
        end
    end

    logic [ADDR_W-1:0] beg_g;
    logic [ADDR_W-1:0] end_g;
    logic [SPAN_W-1:0] span_d;
    logic [SPAN_W-1:0] nxt_d;
    logic [SPAN_W-1:0] last_d;
    logic [ADDR_W-1:0] adv_addr_d;

    assign beg_g      = bus.ch_beg_addr[gnt_idx_q*ADDR_W +: ADDR_W];
    assign end_g      = bus.ch_end_addr[gnt_idx_q*ADDR_W +: ADDR_W];
    assign span_d     = (SPAN_W'(axi_len_q) + SPAN_W'(1)) * SPAN_W'(BYTES);
    assign nxt_d      = {1'b0, ptr_q[gnt_idx_q]} + span_d;
    assign last_d     = nxt_d + span_d - SPAN_W'(1);
    // Wrap when the following burst would not fit entirely inside the region.
    assign adv_addr_d = (last_d > {1'b0, end_g}) ? beg_g : nxt_d[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            load_pend_q <= '0;
            axi_start_q <= 1'b0;
            axi_addr_q  <= '0;
            axi_len_q   <= '0;
            rr_q        <= '0;
            gnt_idx_q   <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                ptr_q[i] <= bus.ch_beg_addr[i*ADDR_W +: ADDR_W];
            end
        end else begin
            done_q <= '0;
            // A channel being granted this cycle already has its pointer latched, so defer its reload.
            for (int i = 0; i < CH_NUM; i++) begin
                if (bus.ch_addr_load[i]) begin
                    if (grant_q[i] || (state_q == ARB && sel_vld_d && sel_idx_d == IDX_W'(i))) begin
                        load_pend_q[i] <= 1'b1;
                    end else begin
                        ptr_q[i] <= bus.ch_beg_addr[i*ADDR_W +: ADDR_W];
                    end
                end
            end

            case (state_q)
                IDLE: begin
                    if ((|bus.ch_req) && bus.axi_ready) begin
                        state_q <= ARB;
                    end
                end
                ARB: begin
                    if (sel_vld_d) begin
                        grant_q     <= CH_NUM'(1) << sel_idx_d;
                        gnt_idx_q   <= sel_idx_d;
                        axi_addr_q  <= ptr_q[sel_idx_d];
                        axi_len_q   <= bus.ch_burst_len[sel_idx_d*LEN_W +: LEN_W];
                        axi_start_q <= 1'b1;
                        state_q     <= START;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                START: begin
                    axi_start_q <= 1'b0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (bus.axi_done) begin
                        done_q[gnt_idx_q]      <= 1'b1;
                        grant_q                <= '0;
                        rr_q                   <= (gnt_idx_q == IDX_W'(CH_NUM - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
                        load_pend_q[gnt_idx_q] <= 1'b0;
                        ptr_q[gnt_idx_q]       <= (bus.ch_addr_load[gnt_idx_q] || load_pend_q[gnt_idx_q])
                                                  ? beg_g : adv_addr_d;
                        state_q                <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ch_grant  = grant_q;
    assign bus.ch_done   = done_q;
    assign bus.axi_start = axi_start_q;
    assign bus.axi_addr  = axi_addr_q;
    assign bus.axi_len   = axi_len_q;
endmodule

// File: tb/tb_axi_burst_arbiter.sv
// Directed bench for axi_burst_arbiter: wrap, round robin, busy master, reloads, reset mid-burst.
module tb_axi_burst_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    axi_burst_arbiter_if #(.CH_NUM(4), .ADDR_W(30), .LEN_W(8)) bus ();

    axi_burst_arbiter #(.CH_NUM(4), .ADDR_W(30), .LEN_W(8), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for a burst start, check it, then complete it with optional reloads.
    task automatic do_burst(input string tag, input int ch, input logic [29:0] addr,
                            input int wait_cyc, input logic [3:0] req_after,
                            input logic [3:0] ld_wait, input logic [3:0] ld_done);
        int n;
        n = 0;
        while (bus.axi_start !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check({tag, ".start"}, 64'(bus.axi_start), 64'(1'b1));
        check({tag, ".grant"}, 64'(bus.ch_grant), 64'(4'b0001 << ch));
        check({tag, ".addr"},  64'(bus.axi_addr), 64'(addr));
        check({tag, ".len"},   64'(bus.axi_len),  64'(8'd15));
        bus.ch_req = req_after;
        step();
        check({tag, ".start_pulse"}, 64'(bus.axi_start), 64'(1'b0));
        bus.ch_addr_load = ld_wait;
        step();
        bus.ch_addr_load = 4'b0000;
        repeat (wait_cyc) step();
        check({tag, ".addr_hold"},  64'(bus.axi_addr), 64'(addr));
        check({tag, ".grant_hold"}, 64'(bus.ch_grant), 64'(4'b0001 << ch));
        bus.axi_done     = 1'b1;
        bus.ch_addr_load = ld_done;
        step();
        bus.axi_done     = 1'b0;
        bus.ch_addr_load = 4'b0000;
        check({tag, ".done"},      64'(bus.ch_done),  64'(4'b0001 << ch));
        check({tag, ".grant_clr"}, 64'(bus.ch_grant), 64'(4'b0000));
        step();
        check({tag, ".done_pulse"}, 64'(bus.ch_done), 64'(4'b0000));
    endtask

    initial begin
        int  n;
        logic seen_start;
        errors = 0;
        checks = 0;

        rst                 = 1'b1;
        bus.ch_req          = 4'b0000;
        bus.ch_beg_addr     = {30'h1800, 30'h1000, 30'h0800, 30'h0000};
        bus.ch_end_addr     = {30'h1FFF, 30'h17FF, 30'h0FFF, 30'h07FF};
        bus.ch_burst_len    = {4{8'd15}};
        bus.ch_addr_load    = 4'b0000;
        bus.axi_ready       = 1'b1;
        bus.axi_done        = 1'b0;
        step();
        step();
        check("rst.grant", 64'(bus.ch_grant),  64'(0));
        check("rst.done",  64'(bus.ch_done),   64'(0));
        check("rst.start", 64'(bus.axi_start), 64'(0));
        check("rst.addr",  64'(bus.axi_addr),  64'(0));
        check("rst.len",   64'(bus.axi_len),   64'(0));
        rst = 1'b0;

        // Busy master: no start while axi_ready is low, then exactly 2 cycles after it rises.
        bus.axi_ready = 1'b0;
        bus.ch_req    = 4'b0001;
        seen_start    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.axi_start === 1'b1) seen_start = 1'b1;
        end
        check("busy.no_start", 64'(seen_start), 64'(1'b0));
        bus.axi_ready = 1'b1;
        step();
        check("busy.lat1", 64'(bus.axi_start), 64'(1'b0));
        step();
        check("busy.lat2", 64'(bus.axi_start), 64'(1'b1));
        do_burst("ch0.b0", 0, 30'h000, 18, 4'b0001, 4'b0000, 4'b0000);

        // Single channel walks the 2 KiB region in 128-byte steps, then wraps.
        for (int k = 1; k < 16; k++) begin
            do_burst($sformatf("ch0.b%0d", k), 0, 30'(k * 128), 18, 4'b0001, 4'b0000, 4'b0000);
        end
        do_burst("ch0.wrap", 0, 30'h000, 18, 4'b0000, 4'b0000, 4'b0000);

        // Spurious axi_done in IDLE must not pulse ch_done or move the pointer.
        step();
        bus.axi_done = 1'b1;
        step();
        bus.axi_done = 1'b0;
        check("spur.done",  64'(bus.ch_done),   64'(0));
        check("spur.start", 64'(bus.axi_start), 64'(0));
        step();
        check("spur.done2", 64'(bus.ch_done),   64'(0));
        bus.ch_req = 4'b0001;
        do_burst("spur.next", 0, 30'h080, 3, 4'b0000, 4'b0000, 4'b0000);

        // Round robin from a fresh reset.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        bus.ch_req = 4'b1111;
        do_burst("rr.ch0", 0, 30'h0000, 3, 4'b1111, 4'b0000, 4'b0000);
        do_burst("rr.ch1", 1, 30'h0800, 3, 4'b1111, 4'b0000, 4'b0000);
        do_burst("rr.ch2", 2, 30'h1000, 3, 4'b1111, 4'b0000, 4'b0000);
        do_burst("rr.ch3", 3, 30'h1800, 3, 4'b1111, 4'b0000, 4'b0000);
        do_burst("rr.ch0b", 0, 30'h0080, 3, 4'b0010, 4'b0000, 4'b0000);

        // Reload of the granted channel mid-burst, then reload coincident with axi_done.
        do_burst("ld.wait", 1, 30'h0880, 3, 4'b0010, 4'b0010, 4'b0000);
        do_burst("ld.apply", 1, 30'h0800, 3, 4'b0010, 4'b0000, 4'b0010);
        // Reload of a non-granted channel takes effect immediately.
        do_burst("ld.done", 1, 30'h0800, 3, 4'b0100, 4'b0100, 4'b0000);
        do_burst("ld.other", 2, 30'h1000, 3, 4'b0100, 4'b0000, 4'b0000);

        // Reset in the middle of a WAIT.
        n = 0;
        while (bus.axi_start !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("mid.start", 64'(bus.axi_start), 64'(1'b1));
        check("mid.addr",  64'(bus.axi_addr),  64'(30'h1080));
        step();
        step();
        step();
        rst = 1'b1;
        step();
        check("mid.grant", 64'(bus.ch_grant),  64'(0));
        check("mid.done",  64'(bus.ch_done),   64'(0));
        check("mid.start0", 64'(bus.axi_start), 64'(0));
        check("mid.addr0", 64'(bus.axi_addr),  64'(0));
        rst = 1'b0;
        step();
        check("mid.idle_lat1", 64'(bus.axi_start), 64'(0));
        check("mid.done2",     64'(bus.ch_done),   64'(0));
        step();
        check("mid.idle_lat2", 64'(bus.axi_start), 64'(1'b1));
        do_burst("post.ch2", 2, 30'h1000, 3, 4'b1011, 4'b0000, 4'b0000);
        do_burst("post.ch3", 3, 30'h1800, 3, 4'b1011, 4'b0000, 4'b0000);
        do_burst("post.ch0", 0, 30'h0000, 3, 4'b1011, 4'b0000, 4'b0000);
        do_burst("post.ch1", 1, 30'h0800, 3, 4'b0000, 4'b0000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
